// File: rtl/size_frame_tx.sv
// Transmit side of the size/data_start/last framing protocol.
// A FWFT word FIFO prefills before data_start because the receiver cannot stall.
module size_frame_tx #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          rst_n,
   input  logic                          req_valid,
   input  logic [31:0]                   req_len,
   output logic                          req_ready,
   input  logic                          src_valid,
   input  logic [DATA_W-1:0]             src_data,
   output logic                          src_ready,
   output logic                          size_valid,
   output logic [31:0]                   size,
   output logic                          data_start,
   output logic                          data_valid,
   output logic [DATA_W-1:0]             data,
   output logic                          last,
   output logic                          busy,
   output logic                          underrun,
   output logic                          zero_drop,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_SIZE, S_PREFILL, S_START, S_DATA} state_t;

   state_t            state_q, state_d;
   logic [31:0]       len_q, len_d;
   logic [31:0]       rem_q, rem_d;
   logic              zero_drop_q, zero_drop_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [LVL_W-1:0]  prefill_thr;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic              full, empty, push, pop;

   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty = (level_q == '0);
   // full blocks a push even when a pop happens in the same cycle
   assign push  = src_valid && !full;
   assign pop   = (state_q == S_DATA) && !empty;

   // short frames only need their own words buffered, long ones a full FIFO
   assign prefill_thr = (len_q >= 32'(FIFO_DEPTH)) ? LVL_W'(FIFO_DEPTH) : len_q[LVL_W-1:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= src_data;
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      rem_d       = rem_q;
      zero_drop_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_len == 32'd0) begin
                  zero_drop_d = 1'b1;
               end else begin
                  len_d   = req_len;
                  rem_d   = req_len;
                  state_d = S_SIZE;
               end
            end
         end
         S_SIZE:    state_d = S_PREFILL;
         S_PREFILL: if (level_q >= prefill_thr) state_d = S_START;
         S_START:   state_d = S_DATA;
         S_DATA: begin
            // leaving at 1 keeps rem from ever wrapping below zero
            rem_d = rem_q - 32'd1;
            if (rem_q == 32'd1) state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         rem_q       <= '0;
         zero_drop_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         zero_drop_q <= zero_drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign src_ready  = !full;
   assign size_valid = (state_q == S_SIZE);
   assign size       = size_valid ? len_q : 32'd0;
   assign data_start = (state_q == S_START);
   assign data_valid = (state_q == S_DATA);
   assign data       = pop ? mem_q[rd_ptr_q] : '0;
   assign last       = data_valid && (rem_q == 32'd1);
   assign busy       = (state_q != S_IDLE);
   assign underrun   = data_valid && empty;
   assign zero_drop  = zero_drop_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_size_frame_tx.sv
// Directed bench for size_frame_tx: a word scoreboard plus a receiver-side size counter model.
module tb_size_frame_tx;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 8;
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        und;
   } beat_t;

   logic              clock = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic [31:0]       req_len = '0;
   logic              req_ready;
   logic              src_valid = 1'b0;
   logic [DATA_W-1:0] src_data = '0;
   logic              src_ready;
   logic              size_valid;
   logic [31:0]       size;
   logic              data_start;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic              last;
   logic              busy;
   logic              underrun;
   logic              zero_drop;
   logic [LVL_W-1:0]  fifo_level;

   size_frame_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock(clock), .rst_n(rst_n),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .size_valid(size_valid), .size(size), .data_start(data_start),
      .data_valid(data_valid), .data(data), .last(last), .busy(busy),
      .underrun(underrun), .zero_drop(zero_drop), .fifo_level(fifo_level)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   beat_t       exp_q[$];
   logic [31:0] wq[$];
   logic [31:0] src_pend[$];
   int          size_cyc_q[$];
   int          last_cyc_q[$];
   int          n_size, n_start, n_zero, n_beats, n_und, n_busy;
   int          start_cyc, start_lvl;
   logic [31:0] size_seen;
   logic [31:0] rx_rem;
   int          h1, h2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      n_size = 0; n_start = 0; n_zero = 0; n_beats = 0; n_und = 0; n_busy = 0;
      start_cyc = 0; start_lvl = 0; size_seen = '0;
      size_cyc_q.delete();
      last_cyc_q.delete();
   endtask

   task automatic rst_check(input string pre);
      chk({pre, "_ctrl"}, {req_ready, src_ready, size_valid, data_start, data_valid,
                           last, busy, underrun, zero_drop}, 64'b110000000);
      chk({pre, "_size_data"}, {size, data}, 64'd0);
      chk({pre, "_level"}, 64'(fifo_level), 64'd0);
   endtask

   task automatic preload(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         src_pend.push_back(base + 32'(i));
         wq.push_back(base + 32'(i));
      end
      for (int k = 0; k < 60 && fifo_level != LVL_W'(n); k++) @(negedge clock);
      chk("preload_level", 64'(fifo_level), 64'(n));
      @(posedge clock); #1;
   endtask

   // Expected beats are fixed at request time from the in-order word model.
   task automatic do_req(input logic [31:0] len, output int hs_cyc);
      bit got;
      got = 1'b0;
      for (int unsigned i = 0; i < len; i++) begin
         beat_t b;
         if (wq.size() > 0) begin b.data = wq.pop_front(); b.und = 1'b0; end
         else begin b.data = '0; b.und = 1'b1; end
         b.last = (i == len - 1);
         exp_q.push_back(b);
      end
      req_valid = 1'b1;
      req_len   = len;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clock);
         if (req_ready) got = 1'b1;
         @(posedge clock); #1;
      end
      hs_cyc    = cyc;
      req_valid = 1'b0;
      req_len   = 32'h5A5A_0003;
      if (!got) chk("req_handshake_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic wait_done(input int max);
      for (int k = 0; k < max && (exp_q.size() != 0 || busy); k++) @(negedge clock);
      chk("frame_done", 64'(busy || exp_q.size() != 0), 64'd0);
      @(posedge clock); #1;
   endtask

   initial begin
      fork
         forever begin
            @(posedge clock);
            cyc++;
         end
         begin : feeder
            bit hs;
            forever begin
               @(negedge clock);
               hs = src_valid && src_ready && rst_n;
               @(posedge clock); #1;
               if (hs && src_pend.size() > 0) void'(src_pend.pop_front());
               if (src_pend.size() > 0) begin src_valid = 1'b1; src_data = src_pend[0]; end
               else begin src_valid = 1'b0; src_data = '0; end
            end
         end
         begin : monitor
            beat_t b;
            forever begin
               @(negedge clock);
               if (rst_n) begin
                  if (size_valid) begin
                     n_size++; size_seen = size; size_cyc_q.push_back(cyc); rx_rem = size;
                  end
                  if (data_start) begin n_start++; start_cyc = cyc; start_lvl = int'(fifo_level); end
                  if (zero_drop) n_zero++;
                  if (busy) n_busy++;
                  if (data_valid) begin
                     n_beats++;
                     if (underrun) n_und++;
                     chk("rx_counter_last", 64'(last), 64'(rx_rem == 32'd1));
                     rx_rem = rx_rem - 32'd1;
                     if (last) last_cyc_q.push_back(cyc);
                     if (exp_q.size() == 0) chk("spurious_beat", 64'(data_valid), 64'd0);
                     else begin
                        b = exp_q.pop_front();
                        chk("beat_data", 64'(data), 64'(b.data));
                        chk("beat_last", 64'(last), 64'(b.last));
                        chk("beat_underrun", 64'(underrun), 64'(b.und));
                     end
                  end else begin
                     chk("idle_outputs_zero", {data, last, underrun}, 64'd0);
                  end
               end
            end
         end
         begin : watchdog
            #400000;
            $display("FAIL watchdog expired checks=%0d", checks);
            $fatal(1);
         end
      join_none

      rx_rem = '0;
      clr_stats();
      #12;
      rst_check("reset");
      @(posedge clock); #1;
      rst_n = 1'b1;
      @(posedge clock); #1;

      // len=4 with words already buffered
      clr_stats();
      preload(32'hA000_0000, 4);
      do_req(32'd4, h1);
      wait_done(100);
      chk("t1_size_count", 64'(n_size), 64'd1);
      chk("t1_size_value", 64'(size_seen), 64'd4);
      chk("t1_size_after_hs", 64'(size_cyc_q[0]), 64'(h1));
      chk("t1_start_gap", 64'(start_cyc - size_cyc_q[0]), 64'd2);
      chk("t1_last_at_word4", 64'(last_cyc_q[0] - start_cyc), 64'd4);
      chk("t1_beats", 64'(n_beats), 64'd4);
      chk("t1_underrun", 64'(n_und), 64'd0);

      // zero-length request: dropped, prefetched words stay put
      clr_stats();
      preload(32'hB000_0000, 2);
      do_req(32'd0, h1);
      repeat (4) @(negedge clock);
      chk("t2_zero_drop", 64'(n_zero), 64'd1);
      chk("t2_no_size", 64'(n_size), 64'd0);
      chk("t2_never_busy", 64'(n_busy), 64'd0);
      chk("t2_fifo_untouched", 64'(fifo_level), 64'd2);
      @(posedge clock); #1;

      // len=20 with the source streaming from the request onward
      clr_stats();
      for (int i = 0; i < 18; i++) begin
         src_pend.push_back(32'hC000_0000 + 32'(i));
         wq.push_back(32'hC000_0000 + 32'(i));
      end
      do_req(32'd20, h1);
      wait_done(300);
      chk("t3_start_level", 64'(start_lvl), 64'(FIFO_DEPTH));
      chk("t3_beats", 64'(n_beats), 64'd20);
      chk("t3_underrun", 64'(n_und), 64'd0);
      chk("t3_last_span", 64'(last_cyc_q[0] - start_cyc), 64'd20);

      // len=12 but only 10 words ever arrive
      clr_stats();
      for (int i = 0; i < 10; i++) begin
         src_pend.push_back(32'hD000_0000 + 32'(i));
         wq.push_back(32'hD000_0000 + 32'(i));
      end
      do_req(32'd12, h1);
      wait_done(300);
      chk("t4_underrun_count", 64'(n_und), 64'd2);
      chk("t4_beats", 64'(n_beats), 64'd12);
      chk("t4_back_to_idle", {busy, req_ready}, 64'b01);

      // back-to-back len=1 then len=2
      clr_stats();
      preload(32'hE000_0000, 3);
      do_req(32'd1, h1);
      do_req(32'd2, h2);
      wait_done(200);
      chk("t5_size_count", 64'(n_size), 64'd2);
      chk("t5_last_count", 64'(last_cyc_q.size()), 64'd2);
      chk("t5_single_beat_last", 64'(last_cyc_q[0] - size_cyc_q[0]), 64'd3);
      chk("t5_gap_ge2", 64'((size_cyc_q[1] - last_cyc_q[0]) >= 2), 64'd1);
      chk("t5_beats", 64'(n_beats), 64'd3);

      // asynchronous reset in the middle of a len=6 frame
      clr_stats();
      preload(32'hF000_0000, 6);
      do_req(32'd6, h1);
      for (int k = 0; k < 100 && n_beats < 2; k++) @(negedge clock);
      chk("t6_mid_data_reached", 64'(data_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      rst_check("t6_async");
      exp_q.delete();
      wq.delete();
      src_pend.delete();
      rx_rem = '0;
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(posedge clock); #1;
      clr_stats();
      preload(32'h1000_0000, 3);
      do_req(32'd3, h1);
      wait_done(100);
      chk("t6_post_beats", 64'(n_beats), 64'd3);
      chk("t6_post_size", 64'(size_seen), 64'd3);
      chk("t6_post_underrun", 64'(n_und), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
